// File: rtl/switch_conditioner_pkg.sv
// Shared constants for the switch conditioner: widths,
// default debounce time and status word layout.
package switch_conditioner_pkg;

  localparam int SW_WIDTH_DEFAULT = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int STATUS_WIDTH = 16;
  localparam int STATUS_PENDING_BIT = 15;
  localparam int STATUS_SW_LSB = 0;

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch lane: two-flop synchronizer, debounce counter,
// stable level flop and sticky change flag.
module switch_debounce_bit
  import switch_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic ack,
  output logic stable,
  output logic evt
);

  localparam int CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast =
    CntW'(DEBOUNCE_CYCLES - 1);

  logic syncMeta;
  logic syncOut;
  logic [CntW-1:0] count;
  logic differs;
  logic qualify;

  assign differs = syncOut ^ stable;
  assign qualify = differs && (count == CntLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncMeta <= 1'b0;
      syncOut  <= 1'b0;
      count    <= '0;
      stable   <= 1'b0;
      evt      <= 1'b0;
    end else begin
      syncMeta <= raw;
      syncOut  <= syncMeta;
      // Count stops at CntLast: the toggle there clears it.
      if (!differs || qualify) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
      if (qualify) begin
        stable <= ~stable;
      end
      // A fresh change beats a same-edge ack.
      if (qualify) begin
        evt <= 1'b1;
      end else if (ack) begin
        evt <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// Debounces a bank of board switches and latches per-switch
// change events for the processor read path.
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SW_WIDTH = SW_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] switches_raw,
  input  logic                ack,
  output logic [SW_WIDTH-1:0] switches_stable,
  output logic [SW_WIDTH-1:0] switch_events,
  output logic                event_pending,
  output logic [15:0]         status_word
);

  generate
    if (DEBOUNCE_CYCLES < 2) begin : gBadDebounce
      $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (SW_WIDTH < 1 || SW_WIDTH > STATUS_PENDING_BIT) begin : gBadWidth
      $error("SW_WIDTH does not fit the status word");
    end
  endgenerate

  for (genvar i = 0; i < SW_WIDTH; i++) begin : gBit
    switch_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uBit (
      .clk   (clk),
      .reset (reset),
      .raw   (switches_raw[i]),
      .ack   (ack),
      .stable(switches_stable[i]),
      .evt   (switch_events[i])
    );
  end

  assign event_pending = |switch_events;

  always_comb begin
    status_word = '0;
    status_word[STATUS_SW_LSB +: SW_WIDTH] = switches_stable;
    status_word[STATUS_PENDING_BIT] = event_pending;
  end

endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 500000, meaning cycles a synchronized input must differ from stable value before the stable value updates (10 ms at 50 MHz).
REQ-002 Parameter: SW_WIDTH, default 10, meaning number of switch inputs.
REQ-003 clk  input  1  system clock, 50 MHz, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 switches_raw  input  SW_WIDTH  raw board switches, asynchronous to clk.
REQ-006 ack  input  1  single-cycle pulse from the processor read path; clears latched events.
REQ-007 switches_stable  output  SW_WIDTH  debounced switch levels; feeds the memory-mapped switch read path.
REQ-008 switch_events  output  SW_WIDTH  sticky per-bit change flags.
REQ-009 event_pending  output  1  OR-reduction of switch_events.
REQ-010 status_word  output  16  {event_pending, 5'b0, switches_stable} with SW_WIDTH=10.

Function
REQ-011 Each switches_raw bit SHALL pass through a two-flop synchronizer; no other logic reads switches_raw.
REQ-012 Per bit, a counter of width clog2(DEBOUNCE_CYCLES) SHALL increment each cycle synced bit differs from stable bit, and clear to 0 on any cycle they match.
REQ-013 When the counter equals DEBOUNCE_CYCLES-1 and synced still differs, the stable bit SHALL toggle on that edge, counter SHALL clear, and the event bit SHALL set.
REQ-014 Latency: a raw change held constant SHALL appear on switches_stable at the (DEBOUNCE_CYCLES+2)th rising edge after the first edge that samples it.
REQ-015 A pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no stable change and no event.
REQ-016 Counter SHALL never wrap; saturation is unreachable by REQ-013.
REQ-017 ack high at an edge SHALL clear every event bit set before that edge.
REQ-018 Simultaneous ack and new event on the same bit or a different bit: the new event SHALL win and remain set after the edge.
REQ-019 Multiple bits qualifying on the same edge SHALL all update and flag on that edge; bits are fully independent.
REQ-020 event_pending and status_word SHALL be combinational from registered state, no added latency.
REQ-021 DEBOUNCE_CYCLES below 2 SHALL be rejected at elaboration.

Reset
REQ-022 reset low SHALL asynchronously force synchronizer flops, counters, switches_stable, switch_events to 0; event_pending and status_word SHALL read 0.
REQ-023 Reset asserted mid-count SHALL discard partial counts; after release counting restarts from 0.
REQ-024 Switches held high through reset release SHALL become stable 1 after REQ-014 latency and SHALL set their event bits.

Structure
REQ-025 Shared package SHALL hold SW_WIDTH, DEBOUNCE_CYCLES default, STATUS_PENDING_BIT=15 and STATUS_SW_LSB=0.
REQ-026 One sub-module switch_debounce_bit (synchronizer, counter, stable flop, event set/clear) SHALL be instantiated SW_WIDTH times; top level holds only the generate loop and output packing.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 reset low, raw=0x000 -> release -> stable=0x000, events=0x000, status_word=0x0000 for 20 cycles.
REQ-028 raw[3] 0->1 held -> stable[3]=1 exactly at 6th edge, events=0x008, status_word=0x8008.
REQ-029 raw[0] high 3 cycles then low -> stable and events remain 0x000.
REQ-030 events=0x008 pending; ack pulse on same edge bit 5 qualifies -> events=0x020, pending=1.
REQ-031 reset low during cycle 3 of bit-7 count -> outputs 0 immediately; after release bit 7 needs full 6 edges.
REQ-032 raw 0x000->0x3FF in one cycle -> stable=0x3FF and events=0x3FF on same edge; ack -> events=0x000, status_word=0x03FF.
